// File: rtl/uart_echo_checker.sv
// Echo-protocol initiator: sends a pattern byte through uart_tx, checks the
// reply from uart_rx equals byte + ADD_CONST, and keeps saturating tallies.
module uart_echo_checker #(
  parameter logic [7:0]  ADD_CONST      = 8'd42,
  parameter int unsigned TIMEOUT_CYCLES = 120_000,
  parameter int unsigned GAP_CYCLES     = 12_000,
  parameter logic [7:0]  SEED           = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [15:0] timeout_count,
  output logic [7:0]  last_sent,
  output logic [7:0]  last_recv,
  output logic        error,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  pattern_q, pattern_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] fail_q, fail_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  last_sent_q, last_sent_d;
  logic [7:0]  last_recv_q, last_recv_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic [7:0]  expect_w;

  assign expect_w = last_sent_q + ADD_CONST;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pattern_d   = pattern_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    last_sent_d = last_sent_q;
    last_recv_d = last_recv_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          tx_data_d   = pattern_q;
          last_sent_d = pattern_q;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 32'd1;
        // A reply arriving on the timeout cycle still counts as a reply
        if (rx_ready) begin
          last_recv_d = rx_data;
          state_d     = S_CHECK;
        end else if (timer_q == TMO_LAST) begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          error_d   = 1'b1;
          pattern_d = pattern_q + 8'd1;
          timer_d   = '0;
          state_d   = S_GAP;
        end
      end
      S_CHECK: begin
        if (last_recv_q == expect_w) begin
          if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
        end else begin
          if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
          error_d = 1'b1;
        end
        pattern_d = pattern_q + 8'd1;
        timer_d   = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = enable ? S_SEND : S_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      pattern_q   <= SEED;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      tmo_q       <= '0;
      last_sent_q <= '0;
      last_recv_q <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pattern_q   <= pattern_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      last_sent_q <= last_sent_d;
      last_recv_q <= last_recv_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign timeout_count = tmo_q;
  assign last_sent     = last_sent_q;
  assign last_recv     = last_recv_q;
  assign error         = error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: pass/fail/timeout paths, pattern
// wrap, tx_busy stall, enable drop and mid-test reset.
module tb_uart_echo_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [15:0] pass_count, fail_count, timeout_count;
  logic [7:0]  last_sent, last_recv;
  logic        error, busy;

  logic        enable1 = 1'b0;
  logic        tx_start1;
  logic [7:0]  tx_data1;
  logic [7:0]  rx_data1 = 8'h00;
  logic        rx_ready1 = 1'b0;
  logic [15:0] pass1, fail1, tmo1;
  logic [7:0]  sent1, recv1;
  logic        error1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_echo_checker #(
    .ADD_CONST(8'd42), .TIMEOUT_CYCLES(100),
    .GAP_CYCLES(20), .SEED(8'h01)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .pass_count(pass_count), .fail_count(fail_count),
    .timeout_count(timeout_count), .last_sent(last_sent),
    .last_recv(last_recv), .error(error), .busy(busy)
  );

  uart_echo_checker #(
    .ADD_CONST(8'd42), .TIMEOUT_CYCLES(100),
    .GAP_CYCLES(20), .SEED(8'hFF)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable1),
    .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(1'b0),
    .rx_data(rx_data1), .rx_ready(rx_ready1),
    .pass_count(pass1), .fail_count(fail1),
    .timeout_count(tmo1), .last_sent(sent1),
    .last_recv(recv1), .error(error1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (tx_start) ok = 1'b1;
    end
  endtask

  task automatic wait_tx1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (tx_start1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok, output int pulses);
    ok = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (tx_start) pulses++;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic reply(input logic [7:0] d, input int lat);
    repeat (lat) tick();
    rx_data = d;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tx_busy = 1'b0;
    rx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_start, tx_data, pass_count, fail_count, timeout_count,
         last_sent, last_recv, error, busy} !== '0) begin
      errors++;
      $display("FAIL reset: start=%b data=%h p=%0d f=%0d t=%0d ls=%h lr=%h err=%b busy=%b, all required 0",
               tx_start, tx_data, pass_count, fail_count, timeout_count,
               last_sent, last_recv, error, busy);
    end
  endtask

  task automatic test_pass();
    bit ok;
    int pulses;
    logic [7:0] want;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tx(ok);
      want = 8'(i + 1);
      checks++;
      if (!ok || tx_data !== want) begin
        errors++;
        $display("FAIL pass_txdata[%0d]: got %h ok=%b, required %h", i, tx_data, ok, want);
      end
      tick();
      checks++;
      if (tx_start !== 1'b0) begin
        errors++;
        $display("FAIL pass_pulse[%0d]: tx_start=%b, required 0", i, tx_start);
      end
      if (i == 2) enable = 1'b0;
      reply(want + 8'd42, 30);
      tick();
      checks++;
      if (pass_count !== 16'(i + 1)) begin
        errors++;
        $display("FAIL pass_count[%0d]: got %0d, required %0d", i, pass_count, i + 1);
      end
    end
    wait_idle(ok, pulses);
    checks++;
    if (!ok || pulses != 0 || fail_count !== 16'd0 || error !== 1'b0
        || pass_count !== 16'd3 || last_recv !== 8'h2D) begin
      errors++;
      $display("FAIL pass_final: idle=%b pulses=%0d p=%0d f=%0d err=%b lr=%h, required 1 0 3 0 0 2d",
               ok, pulses, pass_count, fail_count, error, last_recv);
    end
  endtask

  task automatic test_fail();
    bit ok;
    int pulses;
    do_reset();
    enable = 1'b1;
    wait_tx(ok);
    reply(8'h00, 10);
    tick();
    checks++;
    if (!ok || fail_count !== 16'd1 || last_recv !== 8'h00 || error !== 1'b1
        || pass_count !== 16'd0) begin
      errors++;
      $display("FAIL fail_count: ok=%b f=%0d lr=%h err=%b p=%0d, required 1 1 00 1 0",
               ok, fail_count, last_recv, error, pass_count);
    end
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'h02) begin
      errors++;
      $display("FAIL fail_next: got %h ok=%b, required 02", tx_data, ok);
    end
    enable = 1'b0;
    reply(8'h2C, 10);
    wait_idle(ok, pulses);
    checks++;
    if (!ok || pass_count !== 16'd1 || error !== 1'b1) begin
      errors++;
      $display("FAIL fail_sticky: idle=%b p=%0d err=%b, required 1 1 1", ok, pass_count, error);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int pulses;
    do_reset();
    enable = 1'b1;
    wait_tx(ok);
    enable = 1'b0;
    repeat (99) tick();
    checks++;
    if (!ok || timeout_count !== 16'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: ok=%b t=%0d err=%b, required 1 0 0", ok, timeout_count, error);
    end
    tick();
    checks++;
    if (timeout_count !== 16'd1 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_count: t=%0d err=%b, required 1 1", timeout_count, error);
    end
    reply(8'h2B, 3);
    tick();
    checks++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0 || last_recv !== 8'h00) begin
      errors++;
      $display("FAIL timeout_late: p=%0d f=%0d lr=%h, required 0 0 00",
               pass_count, fail_count, last_recv);
    end
    wait_idle(ok, pulses);
    checks++;
    if (!ok || pulses != 0 || timeout_count !== 16'd1) begin
      errors++;
      $display("FAIL timeout_idle: idle=%b pulses=%0d t=%0d, required 1 0 1", ok, pulses, timeout_count);
    end
  endtask

  task automatic reply1(input logic [7:0] d);
    repeat (10) tick();
    rx_data1 = d;
    rx_ready1 = 1'b1;
    tick();
    rx_ready1 = 1'b0;
  endtask

  task automatic test_seed_wrap();
    bit ok;
    do_reset();
    enable1 = 1'b1;
    wait_tx1(ok);
    checks++;
    if (!ok || tx_data1 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_first: got %h ok=%b, required ff", tx_data1, ok);
    end
    reply1(8'h29);
    tick();
    checks++;
    if (pass1 !== 16'd1 || fail1 !== 16'd0 || error1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pass1: p=%0d f=%0d err=%b, required 1 0 0", pass1, fail1, error1);
    end
    wait_tx1(ok);
    enable1 = 1'b0;
    checks++;
    if (!ok || tx_data1 !== 8'h00) begin
      errors++;
      $display("FAIL wrap_second: got %h ok=%b, required 00", tx_data1, ok);
    end
    reply1(8'h2A);
    tick();
    checks++;
    if (pass1 !== 16'd2 || error1 !== 1'b0 || recv1 !== 8'h2A) begin
      errors++;
      $display("FAIL wrap_pass2: p=%0d err=%b lr=%h, required 2 0 2a", pass1, error1, recv1);
    end
  endtask

  task automatic test_tx_busy();
    bit ok;
    int pulses;
    int early;
    do_reset();
    tx_busy = 1'b1;
    enable = 1'b1;
    early = 0;
    repeat (50) begin
      tick();
      if (tx_start) early++;
    end
    tx_busy = 1'b0;
    checks++;
    if (early != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold: pulses=%0d busy=%b, required 0 1", early, busy);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL busy_release: start=%b data=%h, required 1 01", tx_start, tx_data);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_single: start=%b, required 0", tx_start);
    end
    reply(8'h2B, 5);
    wait_idle(ok, pulses);
    checks++;
    if (!ok || pulses != 0 || pass_count !== 16'd1) begin
      errors++;
      $display("FAIL busy_done: idle=%b pulses=%0d p=%0d, required 1 0 1", ok, pulses, pass_count);
    end
  endtask

  task automatic test_drop_and_reset();
    bit ok;
    int pulses;
    int extra;
    do_reset();
    enable = 1'b1;
    wait_tx(ok);
    tick();
    enable = 1'b0;
    reply(8'h2B, 10);
    wait_idle(ok, pulses);
    extra = 0;
    repeat (40) begin
      tick();
      if (tx_start) extra++;
    end
    checks++;
    if (!ok || pulses != 0 || extra != 0 || pass_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: idle=%b pulses=%0d extra=%0d p=%0d busy=%b, required 1 0 0 1 0",
               ok, pulses, extra, pass_count, busy);
    end
    enable = 1'b1;
    wait_tx(ok);
    checks++;
    if (!ok || tx_data !== 8'h02) begin
      errors++;
      $display("FAIL drop_resume: got %h ok=%b, required 02", tx_data, ok);
    end
    repeat (5) tick();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({tx_start, tx_data, pass_count, fail_count, timeout_count,
         last_sent, last_recv, error, busy} !== '0) begin
      errors++;
      $display("FAIL midreset: start=%b data=%h p=%0d f=%0d t=%0d ls=%h lr=%h err=%b busy=%b, all required 0",
               tx_start, tx_data, pass_count, fail_count, timeout_count,
               last_sent, last_recv, error, busy);
    end
    reply(8'h2C, 2);
    tick();
    checks++;
    if (last_recv !== 8'h00 || pass_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_reply: lr=%h p=%0d busy=%b, required 00 0 0", last_recv, pass_count, busy);
    end
    enable = 1'b1;
    wait_tx(ok);
    enable = 1'b0;
    checks++;
    if (!ok || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL midreset_seed: got %h ok=%b, required 01", tx_data, ok);
    end
    reply(8'h2B, 5);
    wait_idle(ok, pulses);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_seed_wrap();
    test_tx_busy();
    test_drop_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
